// File: rtl/horizontal_tf_pkg.sv
// Shared sizing and types for the horizontal twiddle re-alignment FIFO.
// Build option HTF_BYPASS_EN (see horizontal_tf_fifo.sv) changes behaviour; the sizes here do not.
package horizontal_tf_pkg;

    localparam int P_WIDTH = 64;
    localparam int MUL_LAT = 6;
    localparam int DEPTH   = 16;
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int PTR_W   = $clog2(DEPTH);

    typedef logic [P_WIDTH-1:0] tf_word_t;
    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [PTR_W-1:0]   ptr_t;

endpackage

// File: rtl/horizontal_tf_fifo_if.sv
// Issue-side and butterfly-side signals of the twiddle FIFO.
// slave = the FIFO itself, master = whoever drives the multiplier results and consumes twiddles.
interface horizontal_tf_fifo_if;
    import horizontal_tf_pkg::*;

    logic     mul_issue;
    tf_word_t S_in;
    logic     flush;
    logic     issue_ready;
    tf_word_t tf_out;
    logic     tf_valid;
    logic     tf_ready;
    cnt_t     count;
    logic     overflow_err;

    modport slave (
        input  mul_issue, S_in, flush, tf_ready,
        output issue_ready, tf_out, tf_valid, count, overflow_err
    );

    modport master (
        output mul_issue, S_in, flush, tf_ready,
        input  issue_ready, tf_out, tf_valid, count, overflow_err
    );

endinterface

// File: rtl/horizontal_tf_delay_line.sv
// Latency-matched valid pipe for the modular multiplier, with a running count of set bits.
// clear empties the pipe but still admits this cycle's in_valid into bit 0.
module horizontal_tf_delay_line #(
    parameter int LAT   = 6,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             out_valid,
    output logic [CNT_W-1:0] inflight
);

    logic [LAT-1:0]   pipe;
    logic [CNT_W-1:0] inc;
    logic [CNT_W-1:0] dec;

    assign out_valid = pipe[LAT-1];
    assign inc       = {{(CNT_W-1){1'b0}}, in_valid};
    assign dec       = {{(CNT_W-1){1'b0}}, pipe[LAT-1]};

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe     <= '0;
            inflight <= '0;
        end else if (clear) begin
            pipe     <= {{(LAT-1){1'b0}}, in_valid};
            inflight <= inc;
        end else begin
            pipe     <= {pipe[LAT-2:0], in_valid};
            inflight <= inflight + inc - dec;
        end
    end

endmodule

// File: rtl/horizontal_tf_fifo.sv
// Re-aligns multiplier results (S_in) to the radix-16 butterfly through a credit-guarded FWFT FIFO.
// Define HTF_BYPASS_EN to let a result land directly on tf_out when the FIFO is empty and tf_ready=1.
module horizontal_tf_fifo
    import horizontal_tf_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    horizontal_tf_fifo_if.slave        bus
);

    localparam logic [CNT_W:0] DEPTH_USED = (CNT_W+1)'(DEPTH);

    tf_word_t     mem [DEPTH];
    ptr_t         wr_ptr;
    ptr_t         rd_ptr;
    cnt_t         count_q;
    cnt_t         inflight;
    logic [CNT_W:0] used;
    logic         issue_ready;
    logic         issue_ok;
    logic         wr_valid;
    logic         head_valid;
    logic         bypass;
    logic         push;
    logic         pop;
    logic         overflow_q;
    cnt_t         inc;
    cnt_t         dec;

    // Credits count both stored words and results still inside the multiplier.
    assign used        = {1'b0, count_q} + {1'b0, inflight};
    assign issue_ready = used < DEPTH_USED;
    assign issue_ok    = bus.mul_issue & issue_ready;

    horizontal_tf_delay_line #(
        .LAT   (MUL_LAT),
        .CNT_W (CNT_W)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.flush),
        .in_valid  (issue_ok),
        .out_valid (wr_valid),
        .inflight  (inflight)
    );

    assign head_valid = (count_q != '0);

`ifdef HTF_BYPASS_EN
    assign bypass = !head_valid & wr_valid & bus.tf_ready & !bus.flush;
`else
    assign bypass = 1'b0;
`endif

    // A result arriving during flush belongs to the old stage and is dropped.
    assign push = wr_valid & !bus.flush & !bypass;
    assign pop  = head_valid & bus.tf_ready;
    assign inc  = {{(CNT_W-1){1'b0}}, push};
    assign dec  = {{(CNT_W-1){1'b0}}, pop};

    // NOTE: defaults first in always_comb so no path leaves an output unassigned (no latch).
    always_comb begin
        bus.tf_out   = '0;
        bus.tf_valid = 1'b0;
        if (head_valid) begin
            bus.tf_out   = mem[rd_ptr];
            bus.tf_valid = 1'b1;
        end else if (bypass) begin
            bus.tf_out   = bus.S_in;
            bus.tf_valid = 1'b1;
        end
    end

    // NOTE: the RAM has no reset; tf_out is gated by head_valid so unwritten entries never show.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.S_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ptr_t'(1);
            if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
            count_q <= count_q + inc - dec;
        end
    end

    // Sticky until reset; flush deliberately leaves it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (bus.mul_issue & !issue_ready) begin
            overflow_q <= 1'b1;
        end
    end

    assign bus.issue_ready  = issue_ready;
    assign bus.count        = count_q;
    assign bus.overflow_err = overflow_q;

endmodule

// File: tb/tb_horizontal_tf_fifo.sv
// Directed bench for horizontal_tf_fifo: latency, credits, overflow, streaming, flush, reset.
// Upstream multiplier is modelled as a MUL_LAT-deep data delay feeding S_in.
module tb_horizontal_tf_fifo;
    import horizontal_tf_pkg::*;

    localparam tf_word_t JUNK = 64'hDEAD_BEEF_0000_0000;
`ifdef HTF_BYPASS_EN
    localparam int FIRST = MUL_LAT;
`else
    localparam int FIRST = MUL_LAT + 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    horizontal_tf_fifo_if bus ();

    horizontal_tf_fifo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int       n_total = 0;
    int       n_bad   = 0;
    tf_word_t val_q [MUL_LAT];
    tf_word_t pend;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Advance one cycle; the word offered with this cycle's issue appears on S_in MUL_LAT cycles later.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = MUL_LAT - 1; i > 0; i--) val_q[i] = val_q[i-1];
        val_q[0]  = pend;
        pend      = JUNK;
        bus.S_in  = val_q[MUL_LAT-1];
    endtask

    initial begin
        rst           = 1'b1;
        bus.mul_issue = 1'b0;
        bus.flush     = 1'b0;
        bus.tf_ready  = 1'b0;
        pend          = JUNK;
        for (int i = 0; i < MUL_LAT; i++) val_q[i] = JUNK;
        bus.S_in      = JUNK;

        // Reset state
        #2;
        check1("rst_issue_ready", bus.issue_ready, 1'b1);
        check1("rst_tf_valid", bus.tf_valid, 1'b0);
        check("rst_tf_out", bus.tf_out, 64'h0);
        check("rst_count", 64'(bus.count), 64'h0);
        check1("rst_overflow", bus.overflow_err, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Latency of a single word
        bus.tf_ready  = 1'b1;
        bus.mul_issue = 1'b1;
        pend          = 64'h1234;
        check1("t2_issue_ready", bus.issue_ready, 1'b1);
        tick();
        bus.mul_issue = 1'b0;
        for (int k = 1; k < MUL_LAT; k++) begin
            check1("t2_early_valid", bus.tf_valid, 1'b0);
            tick();
        end
`ifdef HTF_BYPASS_EN
        check1("t2_bypass_valid", bus.tf_valid, 1'b1);
        check("t2_bypass_out", bus.tf_out, 64'h1234);
        check("t2_bypass_count", 64'(bus.count), 64'h0);
        tick();
`else
        check1("t2_wr_cycle_valid", bus.tf_valid, 1'b0);
        check("t2_wr_cycle_count", 64'(bus.count), 64'h0);
        tick();
        check1("t2_valid", bus.tf_valid, 1'b1);
        check("t2_out", bus.tf_out, 64'h1234);
        check("t2_count_one", 64'(bus.count), 64'h1);
        tick();
`endif
        check1("t2_after_valid", bus.tf_valid, 1'b0);
        check("t2_after_count", 64'(bus.count), 64'h0);

        // Credit limit: 16 issues with the butterfly stalled
        bus.tf_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.mul_issue = 1'b1;
            pend          = 64'h100 + 64'(i);
            check1("t3_credit_open", bus.issue_ready, 1'b1);
            tick();
        end
        bus.mul_issue = 1'b0;
        for (int k = 0; k < MUL_LAT; k++) begin
            check1("t3_credit_closed", bus.issue_ready, 1'b0);
            tick();
        end
        check("t3_full_count", 64'(bus.count), 64'd16);
        check1("t3_full_valid", bus.tf_valid, 1'b1);
        check("t3_head", bus.tf_out, 64'h100);
        check1("t3_full_ready", bus.issue_ready, 1'b0);

        // Overflow: illegal issue while full
        bus.mul_issue = 1'b1;
        pend          = 64'hBAD;
        check1("t4_ready_low", bus.issue_ready, 1'b0);
        check1("t4_ovf_before", bus.overflow_err, 1'b0);
        tick();
        bus.mul_issue = 1'b0;
        check1("t4_ovf_set", bus.overflow_err, 1'b1);
        check("t4_count_kept", 64'(bus.count), 64'd16);
        repeat (MUL_LAT + 1) tick();
        check("t4_count_after_lat", 64'(bus.count), 64'd16);
        check("t4_head_kept", bus.tf_out, 64'h100);
        bus.tf_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check1("t4_drain_valid", bus.tf_valid, 1'b1);
            check("t4_drain_data", bus.tf_out, 64'h100 + 64'(i));
            check1("t4_drain_credit", bus.issue_ready, (i > 0));
            tick();
        end
        check1("t4_empty_valid", bus.tf_valid, 1'b0);
        check("t4_empty_count", 64'(bus.count), 64'h0);
        check("t4_empty_out", bus.tf_out, 64'h0);
        check1("t4_ovf_sticky", bus.overflow_err, 1'b1);

        // Steady stream: issue and pop every cycle
        bus.tf_ready = 1'b1;
        for (int c = 0; c < 100 + FIRST + 2; c++) begin
            if (c < 100) begin
                bus.mul_issue = 1'b1;
                pend          = 64'h1000 + 64'(c);
            end else begin
                bus.mul_issue = 1'b0;
            end
            check1("t5_count_le1", (bus.count <= cnt_t'(1)), 1'b1);
            check1("t5_valid", bus.tf_valid, (c >= FIRST) && (c < 100 + FIRST));
            if ((c >= FIRST) && (c < 100 + FIRST))
                check("t5_data", bus.tf_out, 64'h1000 + 64'(c - FIRST));
            tick();
        end
        check("t5_end_count", 64'(bus.count), 64'h0);

        // Flush with 4 stored, 2 in flight, and a new-stage issue in the flush cycle
        bus.tf_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            bus.mul_issue = 1'b1;
            pend          = 64'h600 + 64'(c);
            tick();
        end
        bus.mul_issue = 1'b0;
        repeat (4) tick();
        check("t6_pre_count", 64'(bus.count), 64'd4);
        check("t6_pre_head", bus.tf_out, 64'h600);
        bus.flush     = 1'b1;
        bus.mul_issue = 1'b1;
        pend          = 64'hABCD;
        check1("t6_flush_ready", bus.issue_ready, 1'b1);
        tick();
        bus.flush     = 1'b0;
        bus.mul_issue = 1'b0;
        for (int k = 1; k < MUL_LAT + 1; k++) begin
            check1("t6_flushed_valid", bus.tf_valid, 1'b0);
            check("t6_flushed_count", 64'(bus.count), 64'h0);
            tick();
        end
        check1("t6_new_valid", bus.tf_valid, 1'b1);
        check("t6_new_out", bus.tf_out, 64'hABCD);
        check("t6_new_count", 64'(bus.count), 64'h1);
        check1("t6_ovf_sticky", bus.overflow_err, 1'b1);
        bus.tf_ready = 1'b1;
        tick();
        check1("t6_done_valid", bus.tf_valid, 1'b0);
        check("t6_done_count", 64'(bus.count), 64'h0);

        // Reset mid-stream: 5 stored, 3 in flight
        bus.tf_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            bus.mul_issue = 1'b1;
            pend          = 64'h800 + 64'(c);
            tick();
        end
        bus.mul_issue = 1'b0;
        repeat (3) tick();
        check("t1_pre_count", 64'(bus.count), 64'd5);
        #2;
        rst = 1'b1;
        #1;
        check1("t1_rst_valid", bus.tf_valid, 1'b0);
        check("t1_rst_count", 64'(bus.count), 64'h0);
        check1("t1_rst_ready", bus.issue_ready, 1'b1);
        check1("t1_rst_ovf", bus.overflow_err, 1'b0);
        check("t1_rst_out", bus.tf_out, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.tf_ready = 1'b1;
        for (int k = 0; k < 2 * MUL_LAT + 4; k++) begin
            check1("t1_post_valid", bus.tf_valid, 1'b0);
            check("t1_post_count", 64'(bus.count), 64'h0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
